// File: rtl/rc4_pkg.sv
// Shared RC4 cracker definitions: character-set bounds and the message-checker state encoding.
package rc4_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned KEY_W  = 24;

  localparam logic [BYTE_W-1:0] CHAR_SPACE = 8'd32;
  localparam logic [BYTE_W-1:0] CHAR_A     = 8'd97;
  localparam logic [BYTE_W-1:0] CHAR_Z     = 8'd122;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SEND_ADDR  = 3'd1,
    WAIT_ADDR  = 3'd2,
    CHECK_CHAR = 3'd3,
    PASS       = 3'd4,
    FAIL       = 3'd5,
    DONE       = 3'd6
  } chk_state_e;

endpackage

// File: rtl/char_is_legal.sv
// Combinational test for a plaintext byte: space or lowercase 'a'..'z'.
module char_is_legal
  import rc4_pkg::*;
(
  input  logic [BYTE_W-1:0] i_char,
  output logic              o_legal_c
);

  assign o_legal_c = (i_char == CHAR_SPACE) ||
                     ((i_char >= CHAR_A) && (i_char <= CHAR_Z));

endmodule

// File: rtl/msg_checker.sv
// Scans the decrypted RAM once per Check_Start request, grades the plaintext and
// advances the secret key on failure until the key space is exhausted.
module msg_checker
  import rc4_pkg::*;
#(
  parameter int unsigned      MSG_LEN = 32,
  parameter logic [KEY_W-1:0] KEY_MAX = 24'h3FFFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Check_Start,
  input  logic [BYTE_W-1:0] q_D,
  output logic [BYTE_W-1:0] Address_D,
  output logic              Check_Finish,
  output logic              Msg_Valid,
  output logic [BYTE_W-1:0] Fail_Index,
  output logic [KEY_W-1:0]  Key,
  output logic              Key_Exhausted
);

  localparam logic [BYTE_W-1:0] LAST_IDX = BYTE_W'(MSG_LEN - 1);

  chk_state_e        r_state, w_state_nxt;
  logic [BYTE_W-1:0] r_idx, w_idx_nxt;
  logic [BYTE_W-1:0] r_addr, w_addr_nxt;
  logic              r_finish, w_finish_nxt;
  logic              r_valid, w_valid_nxt;
  logic [BYTE_W-1:0] r_fail_idx, w_fail_idx_nxt;
  logic [KEY_W-1:0]  r_key, w_key_nxt;
  logic              r_kex, w_kex_nxt;
  logic              w_legal;

  char_is_legal u_char_is_legal (
    .i_char    (q_D),
    .o_legal_c (w_legal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_addr     <= '0;
      r_finish   <= 1'b0;
      r_valid    <= 1'b0;
      r_fail_idx <= '0;
      r_key      <= '0;
      r_kex      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_addr     <= w_addr_nxt;
      r_finish   <= w_finish_nxt;
      r_valid    <= w_valid_nxt;
      r_fail_idx <= w_fail_idx_nxt;
      r_key      <= w_key_nxt;
      r_kex      <= w_kex_nxt;
    end
  end

  // Next-state and next-output logic; every byte costs SEND_ADDR + WAIT_ADDR + CHECK_CHAR.
  always_comb begin
    w_state_nxt    = r_state;
    w_idx_nxt      = r_idx;
    w_addr_nxt     = r_addr;
    w_valid_nxt    = r_valid;
    w_fail_idx_nxt = r_fail_idx;
    w_key_nxt      = r_key;
    w_kex_nxt      = r_kex;

    case (r_state)
      IDLE: begin
        if (Check_Start && !r_kex) begin
          w_idx_nxt   = '0;
          w_state_nxt = SEND_ADDR;
        end
      end
      SEND_ADDR:  w_state_nxt = WAIT_ADDR;
      WAIT_ADDR:  w_state_nxt = CHECK_CHAR;
      CHECK_CHAR: begin
        if (!w_legal) begin
          w_fail_idx_nxt = r_idx;
          w_state_nxt    = FAIL;
        end else if (r_idx == LAST_IDX) begin
          w_state_nxt = PASS;
        end else begin
          w_idx_nxt   = r_idx + BYTE_W'(1);
          w_state_nxt = SEND_ADDR;
        end
      end
      PASS: begin
        w_valid_nxt    = 1'b1;
        w_fail_idx_nxt = '0;
        w_state_nxt    = DONE;
      end
      FAIL: begin
        w_valid_nxt = 1'b0;
        if (r_key == KEY_MAX) begin
          w_kex_nxt = 1'b1;
        end else begin
          w_key_nxt = r_key + KEY_W'(1);
        end
        w_state_nxt = DONE;
      end
      DONE: begin
        if (!Check_Start) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // The address is presented for the whole SEND_ADDR/WAIT_ADDR/CHECK_CHAR window.
    if (w_state_nxt == SEND_ADDR) begin
      w_addr_nxt = w_idx_nxt;
    end
    w_finish_nxt = (w_state_nxt == DONE);
  end

  assign Address_D     = r_addr;
  assign Check_Finish  = r_finish;
  assign Msg_Valid     = r_valid;
  assign Fail_Index    = r_fail_idx;
  assign Key           = r_key;
  assign Key_Exhausted = r_kex;

endmodule

// File: tb/tb_msg_checker.sv
// Scoreboard bench for msg_checker with a 2-cycle-latency RAM model behind Address_D/q_D.
`timescale 1ns/1ps
module tb_msg_checker;

  localparam int          MSG_LEN = 32;
  localparam logic [23:0] KEY_MAX = 24'd3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        Check_Start = 1'b0;
  logic [7:0]  q_D = 8'd0;
  logic [7:0]  Address_D;
  logic        Check_Finish;
  logic        Msg_Valid;
  logic [7:0]  Fail_Index;
  logic [23:0] Key;
  logic        Key_Exhausted;

  logic [7:0]  mem [256];
  logic [7:0]  ram_s1 = 8'd0;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int n_done   = 0;
  int m_key    = 0;
  bit m_kex    = 1'b0;
  bit fin_d    = 1'b0;

  typedef struct {
    bit valid;
    int fidx;
    int key;
    bit kex;
    int addr;
    int lat;
    int start_cyc;
  } exp_t;

  exp_t sb_q[$];

  msg_checker #(.MSG_LEN(MSG_LEN), .KEY_MAX(KEY_MAX)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .Check_Start   (Check_Start),
    .q_D           (q_D),
    .Address_D     (Address_D),
    .Check_Finish  (Check_Finish),
    .Msg_Valid     (Msg_Valid),
    .Fail_Index    (Fail_Index),
    .Key           (Key),
    .Key_Exhausted (Key_Exhausted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Registered address plus registered data: q_D reflects Address_D two edges later.
  always @(posedge clk) begin
    ram_s1 <= mem[Address_D];
    q_D    <= ram_s1;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic bit legal(input logic [7:0] b);
    return (b == 8'd32) || (b >= 8'd97 && b <= 8'd122);
  endfunction

  function automatic int first_bad();
    for (int i = 0; i < MSG_LEN; i++) begin
      if (!legal(mem[i])) return i;
    end
    return -1;
  endfunction

  // Pop and grade one expected result on each rising edge of Check_Finish.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && Check_Finish && !fin_d) begin
      if (sb_q.size() == 0) begin
        check("spurious_finish", 32'(Check_Finish), 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("msg_valid",     32'(Msg_Valid),     32'(e.valid));
        check("fail_index",    32'(Fail_Index),    32'(e.fidx));
        check("key",           32'(Key),           32'(e.key));
        check("key_exhausted", 32'(Key_Exhausted), 32'(e.kex));
        check("last_addr",     32'(Address_D),     32'(e.addr));
        check("latency",       32'(cyc - e.start_cyc), 32'(e.lat));
        n_done++;
      end
    end
    fin_d = Check_Finish;
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_addr"},   32'(Address_D),     32'd0);
    check({tag, "_finish"}, 32'(Check_Finish),  32'd0);
    check({tag, "_valid"},  32'(Msg_Valid),     32'd0);
    check({tag, "_fidx"},   32'(Fail_Index),    32'd0);
    check({tag, "_key"},    32'(Key),           32'd0);
    check({tag, "_kex"},    32'(Key_Exhausted), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    Check_Start = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_vals(tag);
    sb_q.delete();
    m_key = 0;
    m_kex = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b1;
  endtask

  // drop_after > 0: release Check_Start after that many edges; hold_extra: keep it high past finish.
  task automatic run_scan(input int drop_after, input int hold_extra);
    exp_t e;
    int   k;
    int   done0;
    bit   got;
    k       = first_bad();
    e.valid = (k < 0);
    e.fidx  = (k < 0) ? 0 : k;
    e.addr  = (k < 0) ? MSG_LEN - 1 : k;
    e.lat   = (k < 0) ? 3 * MSG_LEN + 2 : 3 * k + 5;
    if (k >= 0) begin
      if (m_key == int'(KEY_MAX)) m_kex = 1'b1;
      else m_key++;
    end
    e.key = m_key;
    e.kex = m_kex;
    done0 = n_done;
    @(negedge clk); #1;
    e.start_cyc = cyc;
    sb_q.push_back(e);
    Check_Start = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk); #1;
      if (drop_after > 0 && i + 1 == drop_after) Check_Start = 1'b0;
      if (n_done != done0) got = 1'b1;
    end
    if (!got) begin
      check("scan_timeout", 32'd0, 32'd1);
      sb_q.delete();
      Check_Start = 1'b0;
    end else begin
      for (int i = 0; i < hold_extra; i++) begin
        @(negedge clk); #1;
        check("finish_held", 32'(Check_Finish), 32'd1);
      end
      Check_Start = 1'b0;
      @(negedge clk); #1;
      check("finish_drop",  32'(Check_Finish), 32'd0);
      check("valid_stable", 32'(Msg_Valid),    32'(e.valid));
      check("key_stable",   32'(Key),          32'(e.key));
    end
  endtask

  task automatic fill_boundary();
    for (int i = 0; i < 256; i++) begin
      case (i % 3)
        0:       mem[i] = 8'd32;
        1:       mem[i] = 8'd97;
        default: mem[i] = 8'd122;
      endcase
    end
  endtask

  task automatic fill_random_legal();
    for (int i = 0; i < 256; i++) begin
      if ($urandom_range(0, 5) == 0) mem[i] = 8'd32;
      else mem[i] = 8'(97 + $urandom_range(0, 25));
    end
  endtask

  task automatic plant_random_illegal();
    logic [7:0] v;
    int         idx;
    idx = int'($urandom_range(0, MSG_LEN - 1));
    v   = 8'($urandom_range(0, 255));
    while (legal(v)) v = 8'($urandom_range(0, 255));
    mem[idx] = v;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    string sentence;
    bit    seen;
    logic [7:0] addr0;
    bit    reached;

    sentence = "the quick brown fox jumps over a";
    for (int i = 0; i < 256; i++) mem[i] = 8'd97;

    #12;
    check_reset_vals("por");
    @(negedge clk); #1;
    rst_n = 1'b1;

    // Known-good plaintext, single-cycle request pulse, then with a held request.
    for (int i = 0; i < MSG_LEN; i++) mem[i] = sentence[i];
    run_scan(1, 0);
    run_scan(0, 3);

    for (int i = 0; i < 256; i++) mem[i] = 8'd97;
    mem[5] = 8'h7B;
    run_scan(0, 0);

    fill_boundary();
    run_scan(0, 0);
    mem[0] = 8'd96;
    run_scan(0, 0);
    fill_boundary();
    mem[31] = 8'd123;
    run_scan(0, 0);
    fill_boundary();
    mem[17] = 8'h41;
    run_scan(0, 0);

    // Key space exhausted: a new request must not start a scan.
    addr0 = Address_D;
    seen = 1'b0;
    Check_Start = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); #1;
      if (Check_Finish) seen = 1'b1;
    end
    Check_Start = 1'b0;
    check("exhausted_no_finish", 32'(seen), 32'd0);
    check("exhausted_addr",      32'(Address_D), 32'(addr0));
    check("exhausted_kex",       32'(Key_Exhausted), 32'd1);
    check("exhausted_key",       32'(Key), 32'd3);

    do_reset("rst_idle");

    fill_random_legal();
    plant_random_illegal();
    run_scan(0, 0);

    // Reset in the middle of byte 10.
    fill_random_legal();
    @(negedge clk); #1;
    Check_Start = 1'b1;
    reached = 1'b0;
    for (int i = 0; i < 100 && !reached; i++) begin
      @(negedge clk); #1;
      if (Address_D == 8'd10) reached = 1'b1;
    end
    check("reach_byte10", 32'(reached), 32'd1);
    @(negedge clk); #1;
    do_reset("rst_mid");

    for (int i = 0; i < MSG_LEN; i++) mem[i] = sentence[i];
    run_scan(0, 0);

    fill_random_legal();
    run_scan(20, 0);

    fill_random_legal();
    plant_random_illegal();
    run_scan(0, 0);
    fill_random_legal();
    plant_random_illegal();
    run_scan(7, 0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
